// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic inter-stage registers of the 8-bit core.
//   ST_*        : skid-buffer state encoding (EMPTY / ONE / FULL)
//   *_DATA_W    : default datapath payload width for each core stage boundary
//   *_CTRL_W    : default control payload width for each core stage boundary
// -----------------------------------------------------------------------------
package pipe_pkg;

   // FULL is 2'b11 so that bit 1 alone marks "skid entry occupied".
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b11;

   // IF/ID: PC+1 (8) + instruction word (16)
   localparam int unsigned IF_ID_DATA_W  = 24;
   localparam int unsigned IF_ID_CTRL_W  = 1;
   // ID/EX: PC+1 (8) + rs1/rs2 operands (16) + immediate (8) + rd (3)
   localparam int unsigned ID_EX_DATA_W  = 35;
   localparam int unsigned ID_EX_CTRL_W  = 12;
   // EX/MEM: ALU result (8) + store data (8) + rd (3)
   localparam int unsigned EX_MEM_DATA_W = 19;
   localparam int unsigned EX_MEM_CTRL_W = 5;
   // MEM/WB: writeback value (8) + rd (3)
   localparam int unsigned MEM_WB_DATA_W = 11;
   localparam int unsigned MEM_WB_CTRL_W = 2;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// Valid/ready beat carrying a datapath payload and a control payload.
//   valid : beat valid (producer -> consumer)
//   ready : consumer can take the beat (consumer -> producer)
//   data  : DATA_W datapath payload
//   ctrl  : CTRL_W control payload
// Modports: master = producer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 12
) ();

   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (
      output valid,
      output data,
      output ctrl,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  ctrl,
      output ready
   );

endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter for performance debug.
//   clk   : clock
//   reset : asynchronous active-low reset, clears count
//   inc   : increment this cycle (ignored once count is all ones)
//   clr   : synchronous clear, wins over inc
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised elastic pipeline register between core stages.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   up         : upstream beat (slave): valid/ready/data/ctrl in, ready out
//   dn         : downstream beat (master): valid/data/ctrl out, ready in
//   flush      : synchronous kill of held beats and of the incoming beat
//   clr_cnt    : synchronous clear of both performance counters
//   stall_cnt  : saturating count of cycles with dn.valid=1, dn.ready=0
//   bubble_cnt : saturating count of cycles with dn.valid=0, dn.ready=1
// SKID=1 adds a second entry so up.ready comes straight from a flop;
// SKID=0 is a single register with up.ready = !valid || dn.ready.
// Outputs are all-zero whenever dn.valid is low.
// -----------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 12,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   pipe_stage_reg_if.slave  up,
   pipe_stage_reg_if.master dn,
   input  logic             flush,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   // Main entry M drives the outputs directly.
   logic              m_valid_q;
   logic [DATA_W-1:0] m_data_q;
   logic [CTRL_W-1:0] m_ctrl_q;
   logic [1:0]        state;
   logic              accept;
   logic              consume;

   assign accept  = up.valid && up.ready;
   assign consume = m_valid_q && dn.ready;

   generate
      if (SKID != 0) begin : g_skid
         logic [1:0]        state_q;
         logic              rdy_q;
         logic [DATA_W-1:0] s_data_q;
         logic [CTRL_W-1:0] s_ctrl_q;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               state_q   <= ST_EMPTY;
               rdy_q     <= 1'b1;
               m_valid_q <= 1'b0;
               m_data_q  <= '0;
               m_ctrl_q  <= '0;
               s_data_q  <= '0;
               s_ctrl_q  <= '0;
            end else if (flush) begin
               // The incoming beat still sees its handshake but is dropped.
               state_q   <= ST_EMPTY;
               rdy_q     <= 1'b1;
               m_valid_q <= 1'b0;
               m_data_q  <= '0;
               m_ctrl_q  <= '0;
               s_data_q  <= '0;
               s_ctrl_q  <= '0;
            end else begin
               case (state_q)
                  ST_EMPTY: begin
                     if (accept) begin
                        state_q   <= ST_ONE;
                        m_valid_q <= 1'b1;
                        m_data_q  <= up.data;
                        m_ctrl_q  <= up.ctrl;
                     end
                  end
                  ST_ONE: begin
                     if (accept && consume) begin
                        m_data_q <= up.data;
                        m_ctrl_q <= up.ctrl;
                     end else if (accept) begin
                        state_q  <= ST_FULL;
                        rdy_q    <= 1'b0;
                        s_data_q <= up.data;
                        s_ctrl_q <= up.ctrl;
                     end else if (consume) begin
                        state_q   <= ST_EMPTY;
                        m_valid_q <= 1'b0;
                        m_data_q  <= '0;
                        m_ctrl_q  <= '0;
                     end
                  end
                  ST_FULL: begin
                     if (consume) begin
                        state_q  <= ST_ONE;
                        rdy_q    <= 1'b1;
                        m_data_q <= s_data_q;
                        m_ctrl_q <= s_ctrl_q;
                        s_data_q <= '0;
                        s_ctrl_q <= '0;
                     end
                  end
                  default: begin
                     // Unreachable encoding: recover to a clean empty stage.
                     state_q   <= ST_EMPTY;
                     rdy_q     <= 1'b1;
                     m_valid_q <= 1'b0;
                     m_data_q  <= '0;
                     m_ctrl_q  <= '0;
                     s_data_q  <= '0;
                     s_ctrl_q  <= '0;
                  end
               endcase
            end
         end

         assign up.ready = rdy_q;
         assign state    = state_q;
      end else begin : g_noskid
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               m_valid_q <= 1'b0;
               m_data_q  <= '0;
               m_ctrl_q  <= '0;
            end else if (flush) begin
               m_valid_q <= 1'b0;
               m_data_q  <= '0;
               m_ctrl_q  <= '0;
            end else if (accept) begin
               m_valid_q <= 1'b1;
               m_data_q  <= up.data;
               m_ctrl_q  <= up.ctrl;
            end else if (consume) begin
               m_valid_q <= 1'b0;
               m_data_q  <= '0;
               m_ctrl_q  <= '0;
            end
         end

         assign up.ready = !m_valid_q || dn.ready;
         assign state    = m_valid_q ? ST_ONE : ST_EMPTY;
      end
   endgenerate

   assign dn.valid = m_valid_q;
   assign dn.data  = m_data_q;
   assign dn.ctrl  = m_ctrl_q;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (m_valid_q && !dn.ready),
      .clr   (clr_cnt),
      .count (stall_cnt)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!m_valid_q && dn.ready),
      .clr   (clr_cnt),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg. Three instances share one stimulus:
//   u_a : SKID=1, CNT_W=16   u_b : SKID=1, CNT_W=3   u_c : SKID=0, CNT_W=16
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic [3:0] in_ctrl;
   logic       out_ready;
   logic       flush;
   logic       clr_cnt;

   logic [15:0] stall_a, bubble_a, stall_c, bubble_c;
   logic [2:0]  stall_b, bubble_b;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg_if #(.DATA_W(8), .CTRL_W(4)) up_a ();
   pipe_stage_reg_if #(.DATA_W(8), .CTRL_W(4)) dn_a ();
   pipe_stage_reg_if #(.DATA_W(8), .CTRL_W(4)) up_b ();
   pipe_stage_reg_if #(.DATA_W(8), .CTRL_W(4)) dn_b ();
   pipe_stage_reg_if #(.DATA_W(8), .CTRL_W(4)) up_c ();
   pipe_stage_reg_if #(.DATA_W(8), .CTRL_W(4)) dn_c ();

   assign up_a.valid = in_valid;
   assign up_a.data  = in_data;
   assign up_a.ctrl  = in_ctrl;
   assign dn_a.ready = out_ready;
   assign up_b.valid = in_valid;
   assign up_b.data  = in_data;
   assign up_b.ctrl  = in_ctrl;
   assign dn_b.ready = out_ready;
   assign up_c.valid = in_valid;
   assign up_c.data  = in_data;
   assign up_c.ctrl  = in_ctrl;
   assign dn_c.ready = out_ready;

   pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .SKID(1), .CNT_W(16)) u_a (
      .clk        (clk),
      .reset      (reset),
      .up         (up_a),
      .dn         (dn_a),
      .flush      (flush),
      .clr_cnt    (clr_cnt),
      .stall_cnt  (stall_a),
      .bubble_cnt (bubble_a)
   );

   pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .SKID(1), .CNT_W(3)) u_b (
      .clk        (clk),
      .reset      (reset),
      .up         (up_b),
      .dn         (dn_b),
      .flush      (flush),
      .clr_cnt    (clr_cnt),
      .stall_cnt  (stall_b),
      .bubble_cnt (bubble_b)
   );

   pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .SKID(0), .CNT_W(16)) u_c (
      .clk        (clk),
      .reset      (reset),
      .up         (up_c),
      .dn         (dn_c),
      .flush      (flush),
      .clr_cnt    (clr_cnt),
      .stall_cnt  (stall_c),
      .bubble_cnt (bubble_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] c, input logic r);
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      out_ready = r;
   endtask

   initial begin
      reset = 1'b0;
      flush = 1'b0;
      clr_cnt = 1'b0;
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      tick();
      tick();

      // Reset state
      chk("rst_out_valid", {31'd0, dn_a.valid}, 32'd0);
      chk("rst_out_data", {24'd0, dn_a.data}, 32'h00);
      chk("rst_out_ctrl", {28'd0, dn_a.ctrl}, 32'h0);
      chk("rst_in_ready", {31'd0, up_a.ready}, 32'd1);
      chk("rst_stall_cnt", {16'd0, stall_a}, 32'd0);
      chk("rst_bubble_cnt", {16'd0, bubble_a}, 32'd0);
      chk("rst_state", {30'd0, u_a.state}, {30'd0, ST_EMPTY});
      chk("rst_c_in_ready", {31'd0, up_c.ready}, 32'd1);

      // Streaming at full rate
      reset = 1'b1;
      drive(1'b1, 8'h11, 4'h1, 1'b1);
      clr_cnt = 1'b1;
      chk("str_in_ready0", {31'd0, up_a.ready}, 32'd1);
      tick();
      clr_cnt = 1'b0;
      drive(1'b1, 8'h22, 4'h2, 1'b1);
      chk("str_valid1", {31'd0, dn_a.valid}, 32'd1);
      chk("str_data1", {24'd0, dn_a.data}, 32'h11);
      chk("str_ctrl1", {28'd0, dn_a.ctrl}, 32'h1);
      chk("str_in_ready1", {31'd0, up_a.ready}, 32'd1);
      tick();
      drive(1'b1, 8'h33, 4'h3, 1'b1);
      chk("str_data2", {24'd0, dn_a.data}, 32'h22);
      chk("str_in_ready2", {31'd0, up_a.ready}, 32'd1);
      tick();
      drive(1'b0, 8'h00, 4'h0, 1'b1);
      chk("str_data3", {24'd0, dn_a.data}, 32'h33);
      chk("str_valid3", {31'd0, dn_a.valid}, 32'd1);
      chk("str_stall", {16'd0, stall_a}, 32'd0);
      tick();
      chk("str_drained_valid", {31'd0, dn_a.valid}, 32'd0);
      chk("str_drained_data", {24'd0, dn_a.data}, 32'h00);
      chk("str_drained_ctrl", {28'd0, dn_a.ctrl}, 32'h0);
      chk("str_bubble0", {16'd0, bubble_a}, 32'd0);
      tick();
      chk("str_bubble1", {16'd0, bubble_a}, 32'd1);

      // Backpressure: 0x11 then 0x22 with out_ready low
      drive(1'b1, 8'h11, 4'h4, 1'b0);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      drive(1'b1, 8'h22, 4'h5, 1'b0);
      chk("bp_data_m", {24'd0, dn_a.data}, 32'h11);
      chk("bp_in_ready_one", {31'd0, up_a.ready}, 32'd1);
      chk("bp_stall0", {16'd0, stall_a}, 32'd0);
      tick();
      drive(1'b1, 8'h33, 4'h6, 1'b0);
      chk("bp_state_full", {30'd0, u_a.state}, {30'd0, ST_FULL});
      chk("bp_in_ready_full", {31'd0, up_a.ready}, 32'd0);
      chk("bp_data_held1", {24'd0, dn_a.data}, 32'h11);
      chk("bp_stall1", {16'd0, stall_a}, 32'd1);
      tick();
      chk("bp_in_ready_held", {31'd0, up_a.ready}, 32'd0);
      chk("bp_data_held2", {24'd0, dn_a.data}, 32'h11);
      chk("bp_stall2", {16'd0, stall_a}, 32'd2);
      tick();
      drive(1'b0, 8'h00, 4'h0, 1'b1);
      chk("bp_rel_data0", {24'd0, dn_a.data}, 32'h11);
      chk("bp_rel_valid0", {31'd0, dn_a.valid}, 32'd1);
      chk("bp_stall3", {16'd0, stall_a}, 32'd3);
      tick();
      chk("bp_rel_data1", {24'd0, dn_a.data}, 32'h22);
      chk("bp_rel_ctrl1", {28'd0, dn_a.ctrl}, 32'h5);
      chk("bp_rel_in_ready", {31'd0, up_a.ready}, 32'd1);
      chk("bp_stall_hold", {16'd0, stall_a}, 32'd3);
      tick();
      chk("bp_empty_valid", {31'd0, dn_a.valid}, 32'd0);

      // Flush in FULL while 0x33 is presented
      drive(1'b1, 8'h11, 4'h7, 1'b0);
      tick();
      drive(1'b1, 8'h22, 4'h8, 1'b0);
      tick();
      drive(1'b1, 8'h33, 4'h9, 1'b0);
      flush = 1'b1;
      chk("fl_state_full", {30'd0, u_a.state}, {30'd0, ST_FULL});
      tick();
      flush = 1'b0;
      drive(1'b0, 8'h00, 4'h0, 1'b1);
      chk("fl_out_valid", {31'd0, dn_a.valid}, 32'd0);
      chk("fl_out_ctrl", {28'd0, dn_a.ctrl}, 32'h0);
      chk("fl_out_data", {24'd0, dn_a.data}, 32'h00);
      chk("fl_in_ready", {31'd0, up_a.ready}, 32'd1);
      chk("fl_state_empty", {30'd0, u_a.state}, {30'd0, ST_EMPTY});
      // Flush with an accepted incoming beat: the beat is discarded
      drive(1'b1, 8'h44, 4'ha, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 8'h00, 4'h0, 1'b1);
      chk("fl_in_discard_valid", {31'd0, dn_a.valid}, 32'd0);
      chk("fl_in_discard_data", {24'd0, dn_a.data}, 32'h00);
      tick();
      chk("fl_no_late_beat", {31'd0, dn_a.valid}, 32'd0);

      // Counter saturation on u_b (CNT_W=3)
      drive(1'b1, 8'h55, 4'hb, 1'b0);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      repeat (10) tick();
      chk("sat_stall_b", {29'd0, stall_b}, 32'd7);
      chk("sat_stall_a", {16'd0, stall_a}, 32'd10);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      chk("sat_clr_b", {29'd0, stall_b}, 32'd0);
      chk("sat_clr_a", {16'd0, stall_a}, 32'd0);
      tick();
      chk("sat_resume_b", {29'd0, stall_b}, 32'd1);
      out_ready = 1'b1;
      tick();
      chk("sat_drain_valid", {31'd0, dn_b.valid}, 32'd0);

      // Reset asserted mid-transfer, between clock edges
      drive(1'b1, 8'h66, 4'hc, 1'b0);
      tick();
      drive(1'b0, 8'h00, 4'h0, 1'b0);
      chk("ar_pre_valid", {31'd0, dn_a.valid}, 32'd1);
      chk("ar_pre_data", {24'd0, dn_a.data}, 32'h66);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_valid", {31'd0, dn_a.valid}, 32'd0);
      chk("ar_data", {24'd0, dn_a.data}, 32'h00);
      chk("ar_ctrl", {28'd0, dn_a.ctrl}, 32'h0);
      chk("ar_in_ready", {31'd0, up_a.ready}, 32'd1);
      chk("ar_stall", {16'd0, stall_a}, 32'd0);
      chk("ar_c_valid", {31'd0, dn_c.valid}, 32'd0);
      tick();
      reset = 1'b1;

      // SKID=0 (u_c): combinational in_ready, no beat lost
      drive(1'b1, 8'h11, 4'h1, 1'b1);
      #1;
      chk("ns_in_ready_empty", {31'd0, up_c.ready}, 32'd1);
      tick();
      drive(1'b1, 8'h22, 4'h2, 1'b0);
      #1;
      chk("ns_in_ready_r0", {31'd0, up_c.ready}, 32'd0);
      chk("ns_data_m", {24'd0, dn_c.data}, 32'h11);
      out_ready = 1'b1;
      #1;
      chk("ns_in_ready_r1", {31'd0, up_c.ready}, 32'd1);
      out_ready = 1'b0;
      #1;
      chk("ns_in_ready_r0b", {31'd0, up_c.ready}, 32'd0);
      tick();
      out_ready = 1'b1;
      #1;
      chk("ns_hold_data", {24'd0, dn_c.data}, 32'h11);
      chk("ns_in_ready_r1b", {31'd0, up_c.ready}, 32'd1);
      chk("ns_stall", {16'd0, stall_c}, 32'd1);
      chk("ns_bubble", {16'd0, bubble_c}, 32'd1);
      tick();
      drive(1'b0, 8'h00, 4'h0, 1'b1);
      chk("ns_data2", {24'd0, dn_c.data}, 32'h22);
      chk("ns_ctrl2", {28'd0, dn_c.ctrl}, 32'h2);
      tick();
      chk("ns_empty_valid", {31'd0, dn_c.valid}, 32'd0);
      chk("ns_empty_data", {24'd0, dn_c.data}, 32'h00);
      chk("ns_empty_in_ready", {31'd0, up_c.ready}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register that replaces the fixed-width, fixed-field inter-stage registers of the 8-bit core (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a datapath payload and a control payload under a valid/ready handshake, with an optional 2-entry skid buffer that keeps `in_ready` off the combinational path. Flush inserts a bubble with control forced to zero. Saturating stall/bubble counters support performance debug.

## Interface
- `DATA_W`, 32: datapath payload width (PC+1, register operands, immediate, rd).
- `CTRL_W`, 12: control payload width (alu_op, alu_src, mem_read/write, reg_write, jump, branch, halt, ...).
- `SKID`, 1: 1 = 2-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- `CNT_W`, 16: performance counter width.

- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `in_data`  in  DATA_W  upstream datapath payload.
- `in_ctrl`  in  CTRL_W  upstream control payload.
- `out_valid`  out  1  downstream beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  DATA_W  registered datapath payload.
- `out_ctrl`  out  CTRL_W  registered control payload.
- `flush`  in  1  synchronous kill of all held beats and the incoming beat.
- `clr_cnt`  in  1  synchronous clear of both counters.
- `stall_cnt`  out  CNT_W  cycles with `out_valid=1`, `out_ready=0`.
- `bubble_cnt`  out  CNT_W  cycles with `out_valid=0`, `out_ready=1`.

## Operation
- Accept occurs when `in_valid && in_ready`. Consume occurs when `out_valid && out_ready`.
- Storage is a main entry M, which drives the outputs, and a skid entry S, which exists only when SKID=1.
- SKID=1 state machine:
  - EMPTY: M and S invalid. On accept, go to ONE.
  - ONE: M valid.
    - Accept with consume: M<=in, stay in ONE.
    - Accept without consume: S<=in, go to FULL.
    - Consume only: go to EMPTY.
    - Otherwise, hold.
  - FULL: M and S valid, `in_ready=0`. On consume, M<=S and go to ONE. Otherwise, hold.
  - `in_ready = (state != FULL)`, driven from a register.
- SKID=0:
  - `in_ready = !M_valid || out_ready`.
  - On accept, M<=in.
  - On consume without accept, M is invalidated.
- Bubble rule: `out_data` and `out_ctrl` are 0 whenever `out_valid=0`. Any entry that becomes invalid is cleared to 0.
- Flush has highest priority over accept and consume:
  - M and S are invalidated and cleared.
  - The state goes to EMPTY.
  - An incoming beat in the same cycle completes its handshake upstream but is discarded.
- Counters:
  - Increment per the port definitions and saturate at 2^CNT_W-1.
  - `clr_cnt` overrides the increment in the same cycle.
  - Flush does not affect the counters.
- Beat order is strictly preserved. No beat is duplicated or lost, except by flush.

## Timing
- Reset (asynchronous assert, synchronous deassert handled externally) sets:
  - `out_valid=0`, `out_data=0`, `out_ctrl=0`
  - `stall_cnt=0`, `bubble_cnt=0`, state EMPTY
  - `in_ready=1`
- Latency: a beat accepted at edge N is on `out_*` with `out_valid=1` after edge N (visible in cycle N+1).
- Throughput: 1 beat per cycle sustained while `out_ready=1`.
- SKID=1 absorbs exactly one extra beat after `out_ready` falls. `in_ready` drops the cycle after S fills.
- After a flush at edge N, `out_valid=0` in cycle N+1 and `in_ready=1` in cycle N+1.
- Reset asserted mid-transfer clears everything immediately, regardless of `clk`.
- Counter outputs update on the edge following the counted cycle.

## Structure
- Shared package `pipe_pkg`:
  - State encoding localparams: ST_EMPTY=2'b00, ST_ONE=2'b01, ST_FULL=2'b11.
  - Default widths DATA_W/CTRL_W for each core stage.
- Sub-module `sat_counter` (params CNT_W; ports `clk`, `reset`, `inc`, `clr`, `count`), instantiated twice.
- SKID variants are selected by a generate branch inside `pipe_stage_reg`.

## Test plan
- Reset with SKID=1, DATA_W=8, CTRL_W=4: `out_valid=0`, `out_data=0x00`, `out_ctrl=0x0`, `in_ready=1`, counters 0.
- Stream 0x11,0x22,0x33 with `out_ready=1`: the outputs appear 1 cycle later in order, `in_ready` stays 1, `stall_cnt` stays 0.
- Backpressure with SKID=1:
  - Stimulus: present 0x11, then 0x22, with `out_ready=0`; then release.
  - While held: state FULL, `in_ready=0`, `out_data=0x11`, `stall_cnt` increments each held cycle.
  - After release: 0x11 then 0x22 on consecutive cycles.
- Flush in FULL while presenting 0x33 with `in_valid=1`:
  - Next cycle: `out_valid=0`, `out_ctrl=0`, `in_ready=1`.
  - 0x33 never appears on the output.
- Counter saturation with CNT_W=3:
  - Hold `out_valid=1`, `out_ready=0` for 10 cycles: `stall_cnt` ends at 7.
  - Then `clr_cnt` with the stall still active: `stall_cnt=0` next cycle.
- SKID=0 with `out_ready` toggling 1,0,1: `in_ready` follows `out_ready` combinationally while M is valid, and no beats are lost.
